// File: rtl/and_gate_selftest_ctrl_if.sv
// Handshake and status bundle between the AND-gate self-test sequencer,
// the board-level start/abort/LED logic and the gate under test.
interface and_gate_selftest_ctrl_if #(
  parameter int unsigned ERR_W = 8
);
  logic             start;
  logic             abort;
  logic             dut_in0;
  logic             dut_in1;
  logic             dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             first_fail_valid;
  logic [1:0]       first_fail_vec;
  logic [3:0]       pass_idx;

  // Sequencer side
  modport master (
    input  start, abort, dut_out,
    output dut_in0, dut_in1, busy, done, pass, err_count,
           first_fail_valid, first_fail_vec, pass_idx
  );

  // Board controls plus gate under test
  modport slave (
    output start, abort, dut_out,
    input  dut_in0, dut_in1, busy, done, pass, err_count,
           first_fail_valid, first_fail_vec, pass_idx
  );
endinterface

// File: rtl/and_gate_selftest_ctrl.sv
// Built-in self-test sequencer for a 2-input AND gate: sweeps all four input
// vectors for NUM_PASSES passes, samples the gate after a settle time, counts errors.
module and_gate_selftest_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_PASSES    = 2,
  parameter int unsigned ERR_W         = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  and_gate_selftest_ctrl_if.master  bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned PASS_W = 4;
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(NUM_PASSES - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX     = '1;
  localparam logic [1:0]        VEC_LAST    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0]        vec;
  logic [CNT_W-1:0]  settle_cnt;
  logic [PASS_W-1:0] pass_idx;
  logic [ERR_W-1:0]  err_count;
  logic              first_fail_valid;
  logic [1:0]        first_fail_vec;
  logic              dut_in0;
  logic              dut_in1;
  logic              busy;
  logic              done;
  logic              pass;

  logic accept_c;
  logic abort_c;
  logic sample_c;
  logic mismatch_c;
  logic settle_end_c;
  logic last_vec_c;
  logic last_pass_c;
  logic busy_c;
  logic done_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort outranks every transition except the DONE exit
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept_c) begin
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (abort_c) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort_c) begin
          state_nxt = S_IDLE;
        end else if (settle_end_c) begin
          state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (abort_c) begin
          state_nxt = S_IDLE;
        end else if (last_vec_c && last_pass_c) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_DRIVE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output and datapath-control decode
  always_comb begin
    accept_c     = 1'b0;
    abort_c      = 1'b0;
    sample_c     = 1'b0;
    mismatch_c   = 1'b0;
    settle_end_c = 1'b0;
    last_vec_c   = (vec == VEC_LAST);
    last_pass_c  = (pass_idx == PASS_LAST);
    busy_c       = (state != S_IDLE);
    done_c       = (state == S_DONE);
    unique case (state)
      S_IDLE: begin
        accept_c = bus.start && !bus.abort;
      end
      S_DRIVE: begin
        abort_c = bus.abort;
      end
      S_SETTLE: begin
        abort_c      = bus.abort;
        settle_end_c = (settle_cnt == SETTLE_LAST);
      end
      S_SAMPLE: begin
        abort_c    = bus.abort;
        sample_c   = !bus.abort;
        mismatch_c = !bus.abort && (bus.dut_out != (vec[1] & vec[0]));
      end
      default: begin
        accept_c = 1'b0;
      end
    endcase
  end

  // Settle timer: restarted in DRIVE, counts the SETTLE residency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (state == S_DRIVE) begin
      settle_cnt <= '0;
    end else if (state == S_SETTLE) begin
      settle_cnt <= settle_cnt + CNT_W'(1);
    end
  end

  // Vector / pass sequencing and the gate drive registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec      <= '0;
      pass_idx <= '0;
      dut_in0  <= 1'b0;
      dut_in1  <= 1'b0;
    end else if (accept_c) begin
      vec      <= '0;
      pass_idx <= '0;
      dut_in0  <= 1'b0;
      dut_in1  <= 1'b0;
    end else if (abort_c) begin
      dut_in0 <= 1'b0;
      dut_in1 <= 1'b0;
    end else if (sample_c) begin
      if (!last_vec_c) begin
        vec     <= vec + 2'd1;
        dut_in0 <= ~vec[0];
        dut_in1 <= vec[1] ^ vec[0];
      end else if (!last_pass_c) begin
        vec      <= '0;
        pass_idx <= pass_idx + PASS_W'(1);
        dut_in0  <= 1'b0;
        dut_in1  <= 1'b0;
      end else begin
        dut_in0 <= 1'b0;
        dut_in1 <= 1'b0;
      end
    end
  end

  // Error accounting; the counter saturates instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (accept_c) begin
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (mismatch_c) begin
      if (err_count != ERR_MAX) begin
        err_count <= err_count + ERR_W'(1);
      end
      if (!first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_vec   <= vec;
      end
    end
  end

  // Status flags registered from the decoded state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      busy <= busy_c;
      done <= done_c;
      if (accept_c || abort_c) begin
        pass <= 1'b0;
      end else if (done_c) begin
        pass <= (err_count == '0);
      end
    end
  end

  assign bus.dut_in0          = dut_in0;
  assign bus.dut_in1          = dut_in1;
  assign bus.busy             = busy;
  assign bus.done             = done;
  assign bus.pass             = pass;
  assign bus.err_count        = err_count;
  assign bus.first_fail_valid = first_fail_valid;
  assign bus.first_fail_vec   = first_fail_vec;
  assign bus.pass_idx         = pass_idx;

endmodule

// File: tb/tb_and_gate_selftest_ctrl.sv
// Self-checking bench: two sequencers (ERR_W=8 and ERR_W=2) run in lockstep
// against a timeline model of the self-test run.
module tb_and_gate_selftest_ctrl;

  localparam int S     = 4;
  localparam int P     = 2;
  localparam int PER   = S + 2;
  localparam int TOTAL = 4 * P * PER;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  int   fault_a = 0;
  int   fault_b = 0;
  int   edge_cnt = 0;
  int   done_cnt = 0;
  bit   cmp_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  and_gate_selftest_ctrl_if #(.ERR_W(8)) ifa ();
  and_gate_selftest_ctrl_if #(.ERR_W(2)) ifb ();

  // Gate under test: 0 = good AND, 1 = stuck at 1, 2 = stuck at 0
  function automatic logic gate(logic a, logic b, int f);
    if (f == 1) return 1'b1;
    if (f == 2) return 1'b0;
    return a & b;
  endfunction

  assign ifa.start   = start;
  assign ifa.abort   = abort;
  assign ifa.dut_out = gate(ifa.dut_in0, ifa.dut_in1, fault_a);
  assign ifb.start   = start;
  assign ifb.abort   = abort;
  assign ifb.dut_out = gate(ifb.dut_in0, ifb.dut_in1, fault_b);

  and_gate_selftest_ctrl #(.SETTLE_CYCLES(S), .NUM_PASSES(P), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  and_gate_selftest_ctrl #(.SETTLE_CYCLES(S), .NUM_PASSES(P), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  // Run timeline model: e = edges since the start-accept edge
  typedef struct {
    bit active;
    int e;
    int err;
    bit ffv;
    int ffvec;
    int pidx;
    int din;
    bit busy;
    bit done;
    bit pass;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n.active = 0; n.e = 0; n.err = 0; n.ffv = 0; n.ffvec = 0;
    n.pidx = 0; n.din = 0; n.busy = 0; n.done = 0; n.pass = 0;
    return n;
  endfunction

  function automatic mdl_t step(mdl_t m, logic st, logic ab, int fault, int emax);
    mdl_t n;
    int   k;
    int   v;
    logic want;
    logic got;
    n = m;
    n.done = 0;
    n.busy = m.active;
    if (m.active) begin
      if (m.e == TOTAL) begin
        n.active = 0;
        n.done   = 1;
        n.pass   = (m.err == 0);
      end else if (ab === 1'b1) begin
        n.active = 0;
        n.din    = 0;
        n.pass   = 0;
      end else begin
        n.e = m.e + 1;
        if (n.e % PER == 0) begin
          k    = n.e / PER - 1;
          v    = k % 4;
          want = (v == 3);
          got  = gate(logic'(v % 2), logic'(v / 2), fault);
          if (got != want) begin
            if (n.err < emax) n.err = n.err + 1;
            if (!n.ffv) begin
              n.ffv   = 1;
              n.ffvec = v;
            end
          end
          if (n.e == TOTAL) n.din = 0;
          else begin
            n.din  = (k + 1) % 4;
            n.pidx = (k + 1) / 4;
          end
        end
      end
    end else if (st === 1'b1 && ab !== 1'b1) begin
      n = mdl_reset();
      n.active = 1;
    end
    return n;
  endfunction

  mdl_t ma;
  mdl_t mb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= mdl_reset();
      mb <= mdl_reset();
    end else begin
      ma <= step(ma, start, abort, fault_a, 255);
      mb <= step(mb, start, abort, fault_b, 3);
    end
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) if (!rst && ifa.done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      chk("a.busy", int'(ifa.busy), int'(ma.busy));
      chk("a.done", int'(ifa.done), int'(ma.done));
      chk("a.pass", int'(ifa.pass), int'(ma.pass));
      chk("a.err_count", int'(ifa.err_count), ma.err);
      chk("a.ff_valid", int'(ifa.first_fail_valid), int'(ma.ffv));
      chk("a.ff_vec", int'(ifa.first_fail_vec), ma.ffvec);
      chk("a.pass_idx", int'(ifa.pass_idx), ma.pidx);
      chk("a.dut_in", int'({ifa.dut_in1, ifa.dut_in0}), ma.din);
      chk("b.busy", int'(ifb.busy), int'(mb.busy));
      chk("b.done", int'(ifb.done), int'(mb.done));
      chk("b.pass", int'(ifb.pass), int'(mb.pass));
      chk("b.err_count", int'(ifb.err_count), mb.err);
      chk("b.ff_vec", int'(ifb.first_fail_vec), mb.ffvec);
      chk("b.dut_in", int'({ifb.dut_in1, ifb.dut_in0}), mb.din);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, int'(ifa.busy), 0);
    chk({tag, ".done"}, int'(ifa.done), 0);
    chk({tag, ".pass"}, int'(ifa.pass), 0);
    chk({tag, ".err_count"}, int'(ifa.err_count), 0);
    chk({tag, ".ff_valid"}, int'(ifa.first_fail_valid), 0);
    chk({tag, ".ff_vec"}, int'(ifa.first_fail_vec), 0);
    chk({tag, ".pass_idx"}, int'(ifa.pass_idx), 0);
    chk({tag, ".dut_in"}, int'({ifa.dut_in1, ifa.dut_in0}), 0);
  endtask

  // Pulse start, then follow the run until done; extra_off re-pulses start mid-run
  task automatic run(input int extra_off, output int doff);
    int e0;
    int off;
    int exp_seq [8];
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    doff = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 e0 = edge_cnt; start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      off = edge_cnt - e0;
      start = (off == extra_off);
      if (off < TOTAL && off % PER == 1)
        chk($sformatf("seq.vec%0d", off / PER), int'({ifa.dut_in1, ifa.dut_in0}), exp_seq[off / PER]);
      if (ifa.done === 1'b1) begin
        doff = off;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int doff;
    int e0;
    int dsave;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    rst = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);

    // Good gate
    fault_a = 0; fault_b = 0;
    run(-1, doff);
    chk("good.done_edge", doff, 49);
    chk("good.pass", int'(ifa.pass), 1);
    chk("good.err", int'(ifa.err_count), 0);
    chk("good.ff_valid", int'(ifa.first_fail_valid), 0);
    @(posedge clk); #1 chk("good.busy_after", int'(ifa.busy), 0);

    // Stuck at 1
    fault_a = 1; fault_b = 1;
    run(-1, doff);
    chk("sa1.err", int'(ifa.err_count), 6);
    chk("sa1.ff_vec", int'(ifa.first_fail_vec), 0);
    chk("sa1.ff_valid", int'(ifa.first_fail_valid), 1);
    chk("sa1.pass", int'(ifa.pass), 0);
    chk("sa1.b_err_sat", int'(ifb.err_count), 3);
    chk("sa1.b_pass", int'(ifb.pass), 0);

    // Stuck at 0
    fault_a = 2; fault_b = 2;
    run(-1, doff);
    chk("sa0.err", int'(ifa.err_count), 2);
    chk("sa0.ff_vec", int'(ifa.first_fail_vec), 3);
    chk("sa0.pass", int'(ifa.pass), 0);

    // Abort at edge 20 of a stuck-at-1 run
    fault_a = 1; fault_b = 1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 e0 = edge_cnt; start = 1'b0;
    while (edge_cnt - e0 < 19) begin @(posedge clk); #1; end
    abort = 1'b1;
    dsave = done_cnt;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort.dut_in", int'({ifa.dut_in1, ifa.dut_in0}), 0);
    @(posedge clk); #1;
    chk("abort.busy", int'(ifa.busy), 0);
    chk("abort.err_held", int'(ifa.err_count), 3);
    chk("abort.pass_idx", int'(ifa.pass_idx), 0);
    repeat (60) @(posedge clk);
    #1 chk("abort.no_done", done_cnt, dsave);

    // Restart with good gate
    fault_a = 0; fault_b = 0;
    run(-1, doff);
    chk("restart.done_edge", doff, 49);
    chk("restart.pass", int'(ifa.pass), 1);
    chk("restart.err", int'(ifa.err_count), 0);

    // start and abort together in IDLE
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(posedge clk); #1 chk("start_abort.busy", int'(ifa.busy), 0);

    // start re-pulsed while busy
    run(10, doff);
    chk("busy_start.done_edge", doff, 49);

    // Reset in SETTLE of the second vector
    fault_a = 1; fault_b = 1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 e0 = edge_cnt; start = 1'b0;
    while (edge_cnt - e0 < 9) begin @(posedge clk); #1; end
    chk("pre_rst.err", int'(ifa.err_count), 1);
    dsave = done_cnt;
    #2 rst = 1'b1;
    #1 chk_all_zero("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    repeat (60) @(posedge clk);
    #1 chk("mid_rst.no_done", done_cnt, dsave);

    // Random start/abort/fault traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 9) == 0);
      abort = ($urandom_range(0, 59) == 0);
      if (ifa.busy === 1'b0 && $urandom_range(0, 3) == 0) begin
        fault_a = int'($urandom_range(0, 2));
        fault_b = int'($urandom_range(0, 2));
      end
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (80) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
